instr_fetch_stage: RTL and testbench

Fetch stage directly downstream of the program counter: consumes the 4-bit instruction address every cycle and reads a 16-word synchronous instruction memory. It tags each word with its address and buffers it in a 2-entry queue, then presents it to decode over a valid/ready handshake. Because the PC cannot stall, the stage absorbs short decode stalls, drops words on overrun with a sticky flag, and supports a flush for taken jumps.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_skid_queue.sv | 64 ++++++
 rtl/instr_fetch_stage.sv | 112 +++++++++++
 tb/tb_instr_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths and the queue entry type for the instruction fetch stage.
// The parity option (IFETCH_PARITY_EN) is handled in instr_fetch_stage.
package ifetch_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int QDEPTH    = 2;
  localparam int CNT_W     = 2;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
    logic              perr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_skid_queue.sv
// Two-entry in-order queue of fetch entries. ent0 is always the head;
// a push into a full queue is dropped unless the head leaves on the same edge.
module ifetch_skid_queue
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic         drop
);

  fetch_entry_t     ent0_q, ent0_d;
  fetch_entry_t     ent1_q, ent1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    full    = (cnt_q == CNT_W'(QDEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop && !flush;

    if (flush) begin
      cnt_d = '0;
    end else begin
      if (do_pop) begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // cnt_d already reflects the pop, so the new word lands behind what remains.
      if (do_push) begin
        if (cnt_d == '0) ent0_d = push_entry;
        else             ent1_d = push_entry;
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = ent0_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: synchronous instruction memory, one-cycle read stage, 2-entry skid
// queue to decode, sticky overrun flag. Define IFETCH_PARITY_EN for stored even parity.
module instr_fetch_stage
  import ifetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_addr,
  output logic              overrun,
  output logic              parity_err
);

`ifdef IFETCH_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Memory is deliberately outside the reset domain so a program survives rst.
  logic [MEM_W-1:0] mem_q [MEM_DEPTH];
  logic [MEM_W-1:0] prog_word;
  logic [MEM_W-1:0] rd_word;

`ifdef IFETCH_PARITY_EN
  assign prog_word = {^prog_data, prog_data};
`else
  assign prog_word = prog_data;
`endif

  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_word;
  end

  assign rd_word = mem_q[pc_addr];

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_perr_q, rd_perr_d;
  logic              overrun_q, overrun_d;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              q_push;
  logic              q_empty;
  logic              q_drop;

  always_comb begin
    rd_valid_d = fetch_en && !flush;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_perr_d  = rd_perr_q;
    if (fetch_en) begin
      rd_data_d = rd_word[DATA_W-1:0];
      rd_addr_d = pc_addr;
`ifdef IFETCH_PARITY_EN
      rd_perr_d = ^rd_word;
`else
      rd_perr_d = 1'b0;
`endif
    end
    overrun_d = flush ? 1'b0 : (overrun_q || q_drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_perr_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_perr_q  <= rd_perr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign q_push     = rd_valid_q && !flush;
  assign push_entry = '{addr: rd_addr_q, instr: rd_data_q, perr: rd_perr_q};

  // Handshake: a word transfers to decode on any edge where if_valid && if_ready;
  // the head holds steady while if_valid is high and if_ready is low.
  ifetch_skid_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (if_ready),
    .flush      (flush),
    .head       (head),
    .empty      (q_empty),
    .drop       (q_drop)
  );

  assign if_valid   = !q_empty;
  assign if_instr   = head.instr;
  assign if_addr    = head.addr;
  assign overrun    = overrun_q;
  assign parity_err = if_valid && head.perr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: streaming, stall/overrun, full push+pop,
// flush, read-before-write, async reset and (with IFETCH_PARITY_EN) parity.
module tb_instr_fetch_stage;
  import ifetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc_addr;
  logic              flush;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_addr;
  logic              overrun;
  logic              parity_err;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_addr    (if_addr),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    check({tag, ".valid"}, 32'(if_valid), 32'd1);
    check({tag, ".addr"},  32'(if_addr),  32'(a));
    check({tag, ".instr"}, 32'(if_instr), 32'(d));
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_q();
    fetch_en = 1'b0;
    if_ready = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; pc_addr = '0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; if_ready = 1'b0;

    // program mem[i] = 0x10 + i while held in reset
    for (int i = 0; i < MEM_DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 8'(8'h10 + i);
      step();
    end
    prog_we = 1'b0;
    check("rst.valid", 32'(if_valid), 32'd0);
    check("rst.instr", 32'(if_instr), 32'd0);
    check("rst.addr", 32'(if_addr), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.perr", 32'(parity_err), 32'd0);
    rst = 1'b0;

    // streaming, one word per cycle, 2-cycle address-to-visible latency
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      pc_addr = 4'(c);
      step();
      if (c == 0) check("lat.valid", 32'(if_valid), 32'd0);
      else check_head($sformatf("stream%0d", c - 1), 4'(c - 1), 8'(8'h10 + c - 1));
    end
    check("stream.overrun", 32'(overrun), 32'd0);

    // decode stall: 3 and 4 absorbed, 5 and 6 dropped, then 3, 4, 7
    flush_q();
    fetch_en = 1'b1; if_ready = 1'b1; pc_addr = 4'd3; step();
    pc_addr = 4'd4; if_ready = 1'b0; step(); check_head("stall0", 4'd3, 8'h13);
    pc_addr = 4'd5; step(); check_head("stall1", 4'd3, 8'h13);
    check("stall1.overrun", 32'(overrun), 32'd0);
    pc_addr = 4'd6; step(); check_head("stall2", 4'd3, 8'h13);
    check("stall2.overrun", 32'(overrun), 32'd1);
    pc_addr = 4'd7; step(); check_head("stall3", 4'd3, 8'h13);
    if_ready = 1'b1; pc_addr = 4'd8; step(); check_head("rel0", 4'd4, 8'h14);
    pc_addr = 4'd9; step(); check_head("rel1", 4'd7, 8'h17);
    check("rel1.overrun", 32'(overrun), 32'd1);

    // full queue with push and pop on the same edge: no drop
    flush_q();
    check("flushclr.overrun", 32'(overrun), 32'd0);
    fetch_en = 1'b1; if_ready = 1'b0; pc_addr = 4'd0; step();
    pc_addr = 4'd1; step(); check_head("fp0", 4'd0, 8'h10);
    pc_addr = 4'd2; step(); check_head("fp1", 4'd0, 8'h10);
    if_ready = 1'b1; fetch_en = 1'b0; step(); check_head("fp2", 4'd1, 8'h11);
    check("fp2.overrun", 32'(overrun), 32'd0);
    step(); check_head("fp3", 4'd2, 8'h12);
    step(); check("fp4.valid", 32'(if_valid), 32'd0);
    check("fp4.overrun", 32'(overrun), 32'd0);

    // flush with a full queue, read in flight and overrun set
    flush_q();
    fetch_en = 1'b1; if_ready = 1'b0; pc_addr = 4'd0; step();
    pc_addr = 4'd1; step();
    pc_addr = 4'd2; step();
    pc_addr = 4'd3; step();
    check("pre_flush.overrun", 32'(overrun), 32'd1);
    check_head("pre_flush", 4'd0, 8'h10);
    flush = 1'b1; pc_addr = 4'd4; step(); flush = 1'b0;
    check("flush.valid", 32'(if_valid), 32'd0);
    check("flush.overrun", 32'(overrun), 32'd0);
    pc_addr = 4'd5; step(); check("post_flush0.valid", 32'(if_valid), 32'd0);
    pc_addr = 4'd6; step(); check_head("post_flush1", 4'd5, 8'h15);

    // read-before-write on address 5
    flush_q();
    fetch_en = 1'b1; if_ready = 1'b1; pc_addr = 4'd5;
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'hA5; step();
    prog_we = 1'b0; step(); check_head("rbw_old", 4'd5, 8'h15);
    step(); check_head("rbw_new", 4'd5, 8'hA5);
    check("rbw.perr", 32'(parity_err), 32'd0);

`ifdef IFETCH_PARITY_EN
    // corrupt the stored parity bit of address 2
    flush_q();
    dut.mem_q[2][DATA_W] = ~dut.mem_q[2][DATA_W];
    fetch_en = 1'b1; if_ready = 1'b1; pc_addr = 4'd1; step();
    pc_addr = 4'd2; step(); check_head("par1", 4'd1, 8'h11);
    check("par1.perr", 32'(parity_err), 32'd0);
    pc_addr = 4'd3; step(); check_head("par2", 4'd2, 8'h12);
    check("par2.perr", 32'(parity_err), 32'd1);
    pc_addr = 4'd4; step(); check_head("par3", 4'd3, 8'h13);
    check("par3.perr", 32'(parity_err), 32'd0);
`endif

    // asynchronous reset mid-stream, then memory retention
    flush_q();
    fetch_en = 1'b1; if_ready = 1'b0; pc_addr = 4'd0; step();
    pc_addr = 4'd1; step(); check_head("pre_rst", 4'd0, 8'h10);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 32'(if_valid), 32'd0);
    check("arst.instr", 32'(if_instr), 32'd0);
    check("arst.addr", 32'(if_addr), 32'd0);
    step(); rst = 1'b0;
    fetch_en = 1'b1; if_ready = 1'b1; pc_addr = 4'd5; step();
    fetch_en = 1'b0; step(); check_head("retain", 4'd5, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
